// File: rtl/pulse_classify.sv
// Pulse-width symbol decoder: classifies each high pulse as short/long against 1.5 x minimum.
// Optional long-low "gap" detector is enabled with `define PULSE_CLASSIFY_GAP_EN.
module pulse_classify #(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  input  logic [N_BITS-1:0] minimum,
  input  logic              min_valid,
  output logic              sym_valid,
  output logic              sym_long,
  output logic [N_BITS-1:0] sym_len,
  output logic              overflow,
  output logic              gap
);

  typedef enum logic [1:0] {
    WAIT0 = 2'd0,
    IDLE  = 2'd1,
    HIGH  = 2'd2
  } state_t;

  localparam logic [N_BITS-1:0] CNT_MAX = {N_BITS{1'b1}};

  state_t            state_q, state_d;
  logic [N_BITS-1:0] cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic [N_BITS:0]   thr_q, thr_d;
  logic              thr_ok_q, thr_ok_d;
  logic              sym_valid_q, sym_valid_d;
  logic              sym_long_q, sym_long_d;
  logic [N_BITS-1:0] sym_len_q, sym_len_d;
  logic              overflow_q, overflow_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT0:   state_d = pulse_in ? WAIT0 : IDLE;
      IDLE:    state_d = pulse_in ? HIGH : IDLE;
      HIGH:    state_d = pulse_in ? HIGH : IDLE;
      default: state_d = WAIT0;
    endcase
  end

  // Length counter saturates; sat marks that at least one increment was lost.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    case (state_q)
      IDLE: begin
        cnt_d = pulse_in ? {{(N_BITS-1){1'b0}}, 1'b1} : {N_BITS{1'b0}};
        sat_d = 1'b0;
      end
      HIGH: begin
        if (!pulse_in) begin
          cnt_d = {N_BITS{1'b0}};
          sat_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          sat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(N_BITS-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        cnt_d = {N_BITS{1'b0}};
        sat_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    if (min_valid) begin
      thr_d    = {1'b0, minimum} + {2'b00, minimum[N_BITS-1:1]};
      thr_ok_d = 1'b1;
    end else begin
      thr_d    = thr_q;
      thr_ok_d = thr_ok_q;
    end
  end

  // Symbol outputs: strobe for one cycle, payload held until the next symbol.
  always_comb begin
    sym_valid_d = (state_q == HIGH) && !pulse_in && thr_ok_q;
    if (sym_valid_d) begin
      sym_len_d  = cnt_q;
      overflow_d = sat_q;
      sym_long_d = sat_q || ({1'b0, cnt_q} > thr_q);
    end else begin
      sym_len_d  = sym_len_q;
      overflow_d = overflow_q;
      sym_long_d = sym_long_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= {N_BITS{1'b0}};
      sat_q       <= 1'b0;
      thr_q       <= {(N_BITS+1){1'b0}};
      thr_ok_q    <= 1'b0;
      sym_valid_q <= 1'b0;
      sym_long_q  <= 1'b0;
      sym_len_q   <= {N_BITS{1'b0}};
      overflow_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      thr_q       <= thr_d;
      thr_ok_q    <= thr_ok_d;
      sym_valid_q <= sym_valid_d;
      sym_long_q  <= sym_long_d;
      sym_len_q   <= sym_len_d;
      overflow_q  <= overflow_d;
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_long  = sym_long_q;
  assign sym_len   = sym_len_q;
  assign overflow  = overflow_q;

`ifdef PULSE_CLASSIFY_GAP_EN
  localparam logic [N_BITS+1:0] LOW_MAX = {(N_BITS+2){1'b1}};

  logic [N_BITS+1:0] low_q, low_d;
  logic [N_BITS+1:0] limit_s;
  logic              gap_done_q, gap_done_d;
  logic              gap_q, gap_d;

  assign limit_s = {thr_q, 1'b0};

  // The sample that ends a pulse (or arms WAIT0) is the first counted low cycle.
  always_comb begin
    low_d      = low_q;
    gap_done_d = gap_done_q;
    gap_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          low_d      = {(N_BITS+2){1'b0}};
          gap_done_d = 1'b0;
        end else if (low_q != LOW_MAX) begin
          low_d = low_q + {{(N_BITS+1){1'b0}}, 1'b1};
        end else begin
          low_d = low_q;
        end
      end
      default: begin
        low_d      = pulse_in ? {(N_BITS+2){1'b0}} : {{(N_BITS+1){1'b0}}, 1'b1};
        gap_done_d = 1'b0;
      end
    endcase
    if ((state_d == IDLE) && !gap_done_d && thr_ok_q && (low_d >= limit_s)) begin
      gap_d      = 1'b1;
      gap_done_d = 1'b1;
    end else begin
      gap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_q      <= {(N_BITS+2){1'b0}};
      gap_done_q <= 1'b0;
      gap_q      <= 1'b0;
    end else begin
      low_q      <= low_d;
      gap_done_q <= gap_done_d;
      gap_q      <= gap_d;
    end
  end

  assign gap = gap_q;
`else
  assign gap = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_classify.sv
// Self-checking bench for pulse_classify: directed scenarios plus random pulse trains,
// checked each cycle against a pulse-level reference model (8-bit and 4-bit instances).
module tb_pulse_classify;

  logic       clk = 1'b0;
  logic       reset;
  logic       pulse_in;
  logic [7:0] minimum;
  logic [3:0] minimum4;
  logic       min_valid;

  logic       sym_valid, sym_long, overflow, gap;
  logic [7:0] sym_len;
  logic       v4, long4, ovf4, gap4;
  logic [3:0] len4;

  pulse_classify #(.N_BITS(8)) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .minimum(minimum),
    .min_valid(min_valid), .sym_valid(sym_valid), .sym_long(sym_long),
    .sym_len(sym_len), .overflow(overflow), .gap(gap)
  );

  pulse_classify #(.N_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .minimum(minimum4),
    .min_valid(min_valid), .sym_valid(v4), .sym_long(long4),
    .sym_len(len4), .overflow(ovf4), .gap(gap4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit armed, thr_ok, gap_done;
  int run_len, low_run, thr8, thr4;
  int last_len8, last_len4;
  bit e_valid, e_long8, e_ovf8, e_long4, e_ovf4, e_gap;

  // observations captured at strobes
  int nstrobe = 0;
  int ngap = 0;
  int s0;
  int cap_len, cap_len4;
  bit cap_long, cap_ovf, cap_long4, cap_ovf4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic classify(input int len, input int thr, input int maxv,
                          output int o_len, output bit o_long, output bit o_ovf);
    o_ovf  = (len > maxv);
    o_len  = o_ovf ? maxv : len;
    o_long = o_ovf || (o_len > thr);
  endtask

  task automatic model_reset();
    armed = 0; thr_ok = 0; gap_done = 0;
    run_len = 0; low_run = 0; thr8 = 0; thr4 = 0;
    last_len8 = 0; last_len4 = 0;
  endtask

  task automatic gap_eval();
`ifdef PULSE_CLASSIFY_GAP_EN
    if (thr_ok && !gap_done && low_run >= 2 * thr8) begin
      e_gap = 1;
      gap_done = 1;
    end
`endif
  endtask

  task automatic model_edge(input logic p, input logic mv, input int m);
    e_valid = 0;
    e_gap   = 0;
    if (!armed) begin
      if (!p) begin
        armed = 1; low_run = 1; gap_done = 0;
        gap_eval();
      end
    end else if (p) begin
      run_len++; low_run = 0; gap_done = 0;
    end else begin
      if (run_len > 0 && thr_ok) begin
        e_valid = 1;
        classify(run_len, thr8, 255, last_len8, e_long8, e_ovf8);
        classify(run_len, thr4, 15, last_len4, e_long4, e_ovf4);
      end
      run_len = 0;
      low_run++;
      gap_eval();
    end
    if (mv) begin
      thr8 = (m % 256) + (m % 256) / 2;
      thr4 = (m % 16) + (m % 16) / 2;
      thr_ok = 1;
    end
  endtask

  task automatic compare();
    check("sym_valid", sym_valid, e_valid);
    check("sym_valid4", v4, e_valid);
    if (e_valid) begin
      check("sym_long", sym_long, e_long8);
      check("overflow", overflow, e_ovf8);
      check("sym_long4", long4, e_long4);
      check("overflow4", ovf4, e_ovf4);
    end
    check("sym_len", sym_len, last_len8);
    check("sym_len4", len4, last_len4);
    check("gap", gap, e_gap);
    if (sym_valid === 1'b1) begin
      nstrobe++;
      cap_len = sym_len; cap_long = sym_long; cap_ovf = overflow;
      cap_len4 = len4; cap_long4 = long4; cap_ovf4 = ovf4;
    end
    if (gap === 1'b1) ngap++;
  endtask

  task automatic step(input logic p, input logic mv, input int m);
    pulse_in = p; min_valid = mv; minimum = m[7:0]; minimum4 = m[3:0];
    @(posedge clk);
    model_edge(p, mv, m);
    #1;
    compare();
  endtask

  task automatic pulse(input int hi, input int lo, input logic mv, input int m);
    repeat (hi) step(1'b1, mv, m);
    repeat (lo) step(1'b0, mv, m);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, sym_valid, 0);
    check({tag, "_long"}, sym_long, 0);
    check({tag, "_len"}, sym_len, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_gap"}, gap, 0);
    check({tag, "_len4"}, len4, 0);
  endtask

  task automatic do_reset(input logic p, input int cycles);
    pulse_in = p; min_valid = 1'b1; minimum = 8'd4; minimum4 = 4'd4;
    reset = 1'b1;
    model_reset();
    #1;
    check_zero("rst_async");
    repeat (cycles) @(posedge clk);
    #1;
    check_zero("rst_hold");
    reset = 1'b0;
  endtask

  initial begin
    do_reset(1'b1, 3);

    // line high out of reset is ignored, then a 4-cycle short pulse
    repeat (10) step(1'b1, 1'b1, 4);
    repeat (2) step(1'b0, 1'b1, 4);
    check("t1_none_before", nstrobe, 0);
    pulse(4, 2, 1'b1, 4);
    check("t1_strobes", nstrobe, 1);
    check("t1_len", cap_len, 4);
    check("t1_long", cap_long, 0);

    // exactly 1.5 x minimum is short, one more cycle is long
    pulse(6, 2, 1'b1, 4);
    check("t2_len6", cap_len, 6);
    check("t2_short6", cap_long, 0);
    pulse(7, 2, 1'b1, 4);
    check("t2_long7", cap_long, 1);

    // threshold drops mid-pulse: the compare uses the threshold at the falling edge
    repeat (3) step(1'b1, 1'b1, 4);
    repeat (2) step(1'b1, 1'b1, 2);
    step(1'b0, 1'b1, 2);
    step(1'b0, 1'b1, 2);
    check("t2b_len", cap_len, 5);
    check("t2b_long", cap_long, 1);

    // no valid minimum: pulses are discarded
    do_reset(1'b0, 2);
    s0 = nstrobe;
    repeat (5) pulse(3, 2, 1'b0, 0);
    check("t3_discard", nstrobe, s0);
    pulse(5, 2, 1'b1, 3);
    check("t3_strobe", nstrobe, s0 + 1);
    check("t3_len", cap_len, 5);
    check("t3_long", cap_long, 1);

    // 4-bit saturation
    pulse(20, 2, 1'b1, 2);
    check("t4_len4", cap_len4, 15);
    check("t4_ovf4", cap_ovf4, 1);
    check("t4_long4", cap_long4, 1);
    check("t4_len8", cap_len, 20);
    check("t4_ovf8", cap_ovf, 0);

    // back-to-back 1-high/1-low symbols
    s0 = nstrobe;
    repeat (8) pulse(1, 1, 1'b1, 1);
    check("t5_count", nstrobe, s0 + 8);
    check("t5_short", cap_long, 0);

    // reset in the middle of a pulse; the pulse continuing after release is ignored
    repeat (3) step(1'b1, 1'b1, 4);
    s0 = nstrobe;
    do_reset(1'b1, 2);
    repeat (4) step(1'b1, 1'b1, 4);
    repeat (2) step(1'b0, 1'b1, 4);
    check("t6_no_strobe", nstrobe, s0);

    // low-gap detection around 3 x minimum
    s0 = ngap;
    pulse(4, 11, 1'b1, 4);
    pulse(4, 0, 1'b1, 4);
`ifdef PULSE_CLASSIFY_GAP_EN
    check("t7_gap11", ngap, s0);
    repeat (12) step(1'b0, 1'b1, 4);
    pulse(4, 0, 1'b1, 4);
    check("t7_gap12", ngap, s0 + 1);
`else
    repeat (12) step(1'b0, 1'b1, 4);
    pulse(4, 0, 1'b1, 4);
    check("t7_gap_off", ngap, 0);
`endif
    step(1'b0, 1'b1, 4);

    // 8-bit saturation
    pulse(260, 2, 1'b1, 100);
    check("t8_len", cap_len, 255);
    check("t8_ovf", cap_ovf, 1);
    check("t8_long", cap_long, 1);

    // random pulse trains against the reference model
    for (int i = 0; i < 80; i++) begin
      int m;
      logic mv;
      m  = $urandom_range(0, 15);
      mv = ($urandom_range(0, 3) != 0);
      pulse($urandom_range(1, 24), $urandom_range(1, 14), mv, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_classify.md
# pulse_classify

Pulse-width symbol decoder that sits directly downstream of the minimum-pulse-length tracker. It measures every high pulse on the same input line and compares it against a threshold of 1.5 × the tracked minimum. Each completed pulse is emitted as one short/long symbol with its measured length. Typical use is in the cassette/FSK-style input path, where the shortest observed pulse defines the "short" symbol.

## Interface
- `N_BITS`, default 8: width of length counters, `minimum` and `sym_len`.
- `clk`  in  1: system clock; all logic on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `pulse_in`  in  1: pulse line, already synchronous to `clk` (same signal that feeds the minimum tracker).
- `minimum`  in  N_BITS: shortest pulse length in cycles, from the upstream tracker.
- `min_valid`  in  1: high when `minimum` is meaningful.
- `sym_valid`  out  1: one-cycle strobe, symbol available.
- `sym_long`  out  1: 1 = long pulse, 0 = short; qualified by `sym_valid`.
- `sym_len`  out  N_BITS: measured high length of the symbol; held until the next symbol.
- `overflow`  out  1: the symbol's length saturated; qualified by `sym_valid`.
- `gap`  out  1: one-cycle strobe, long low period detected (`PULSE_CLASSIFY_GAP_EN` only).

## Operation
- States:
  - WAIT0: after reset. Ignore the line until `pulse_in` = 0 is sampled, then go to IDLE. A pulse already high at reset is never measured.
  - IDLE: line low. On a sample of `pulse_in` = 1, go to HIGH with `cnt` = 1.
  - HIGH: each cycle `pulse_in` = 1, `cnt` += 1, saturating at all-ones and setting the internal `sat` flag. On the first sample of `pulse_in` = 0, emit a symbol, then return to IDLE and clear `cnt` and `sat`.
- Length convention: `sym_len` = number of rising edges at which `pulse_in` was sampled 1.
- Threshold register `thr`, N_BITS+1 bits:
  - Every cycle `min_valid` = 1, `thr` is loaded with `minimum` + (`minimum` >> 1), no truncation.
  - `thr` holds its value while `min_valid` = 0.
  - Reset clears `thr` and the internal `thr_ok` flag. `thr_ok` sets on the first cycle `min_valid` = 1.
- Symbol emission at a falling edge:
  - If `thr_ok` = 1: `sym_valid` = 1, `sym_len` = `cnt`, `overflow` = `sat`, `sym_long` = (`cnt` > `thr`), a strict compare in N_BITS+1 bits.
  - If `thr_ok` = 0: the pulse is discarded silently and no strobe is produced.
- A pulse of exactly `minimum` × 1.5 classifies as short.
- A saturated pulse always classifies as long.
- A threshold change while in HIGH affects the compare made at the falling edge, using `thr` as it stands on that edge.
- Reset mid-pulse: return to WAIT0, and all outputs go to 0.

## Timing
- Reset values:
  - All outputs 0.
  - State WAIT0; `cnt`, `thr`, `thr_ok` and `sat` = 0.
- `sym_valid`, `sym_long`, `sym_len` and `overflow` are registered at the clock edge that samples the first 0. Visible latency is 1 cycle after the falling edge of the line.
- `sym_valid` and `gap` are high for exactly one cycle.
- Back-to-back symbols are possible every 2 cycles (1 high, 1 low); no handshake or backpressure.
- `thr` is updated at the edge sampling `min_valid` = 1, so it is usable by a compare on the next edge.

## Configuration
- `PULSE_CLASSIFY_GAP_EN` defined:
  - An N_BITS+2-bit low counter runs in IDLE, saturating, and clears on entering HIGH.
  - When it reaches `thr` × 2 (about 3 × `minimum`) and `thr_ok` = 1, `gap` pulses once for that low period.
  - A low counter still below the limit at a rising edge produces no `gap`.
- `PULSE_CLASSIFY_GAP_EN` undefined: no low counter is built, and `gap` is tied to 0.

## Test plan
- Reset with `pulse_in` = 1 held 10 cycles, then low, then a 4-cycle high pulse with `minimum` = 4 and `min_valid` = 1 -> the initial high is ignored; one strobe with `sym_len` = 4 and `sym_long` = 0.
- `minimum` = 4 (`thr` = 6), pulses of 6 and then 7 cycles -> `sym_long` = 0, then 1.
- `min_valid` = 0 throughout, 5 pulses -> no `sym_valid`. Then `min_valid` = 1 with `minimum` = 3 and a 5-cycle pulse -> `sym_long` = 1, `sym_len` = 5.
- N_BITS = 4, `minimum` = 2, a 20-cycle pulse -> `sym_len` = 15, `overflow` = 1, `sym_long` = 1.
- Alternating 1-high/1-low pattern with `minimum` = 1 -> `sym_valid` every 2nd cycle, all short. Reset asserted mid-pulse -> no strobe, and the outputs return to 0.
- With `PULSE_CLASSIFY_GAP_EN`, `minimum` = 4: 11 low cycles -> no `gap`; 12 low cycles -> exactly one `gap` strobe.
